// File: rtl/fir_channel_scheduler.sv
// fir_channel_scheduler
// Time-shares one pipelined accumulator tree among CH channels. A round-robin
// arbiter issues at most one grant per cycle. A tag pipeline as deep as the
// tree carries the granted channel so that each tree result can be labelled.
// The tag is checked against the tree's own output valid, and any disagreement
// raises a sticky error flag.
module fir_channel_scheduler #(
  parameter int CH   = 4,
  parameter int TAPS = 401,
  parameter int LAT  = $clog2(TAPS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic [CH-1:0]         req,
  output logic [CH-1:0]         gnt,
  output logic                  tree_in_valid,
  output logic [$clog2(CH)-1:0] tree_sel,
  input  logic                  tree_out_valid,
  output logic                  res_valid,
  output logic [$clog2(CH)-1:0] res_ch,
  output logic                  busy,
  output logic                  err
);

  localparam int SW = $clog2(CH);
  localparam int IW = $clog2(LAT + 2);

  // Reject parameter sets that the arbiter and tag pipeline cannot represent.
  if (CH < 2 || CH > 16 || LAT < 1 || TAPS < 1) begin : g_param_check
    $error("fir_channel_scheduler: unsupported CH/TAPS/LAT combination");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t          state_q;
  logic [CH-1:0]   gnt_q;
  logic            tiv_q;
  logic [SW-1:0]   sel_q;
  logic [SW-1:0]   last_q;
  logic            busy_q;

  logic            go;
  logic            issue;
  logic [CH-1:0]   req_rot;
  logic [SW-1:0]   pick_off;
  logic [SW:0]     pick_sum;
  logic [SW-1:0]   pick_idx;

  logic [LAT:1]    tag_vld_q;
  logic [SW-1:0]   tag_ch_q [1:LAT];

  logic [IW-1:0]   inflight_q;
  logic [IW-1:0]   inflight_d;
  logic            err_q;

  // A grant is possible only when enabled, something is requesting, and the
  // FSM is in a granting state. A DRAIN->RUN transition costs one idle cycle.
  assign go    = en & (|req);
  assign issue = go & ((state_q == IDLE) | (state_q == RUN));

  // Round-robin pick: rotate the requests so that bit 0 is the channel just
  // after last_q. The lowest set bit of the rotated vector is then the winner.
  always_comb begin
    req_rot  = CH'({req, req} >> ({1'b0, last_q} + (SW+1)'(1)));
    pick_off = '0;
    for (int j = CH - 1; j >= 0; j--) begin
      if (req_rot[j]) pick_off = SW'(j);
    end
    pick_sum = {1'b0, last_q} + {1'b0, pick_off} + (SW+1)'(1);
    if (pick_sum >= (SW+1)'(CH)) pick_sum = pick_sum - (SW+1)'(CH);
    pick_idx = pick_sum[SW-1:0];
  end

  // In-flight count after this edge. An issue and a retire in the same cycle
  // cancel, so the count never goes beyond the tree depth plus one.
  always_comb begin
    inflight_d = inflight_q;
    if (tiv_q && !tag_vld_q[LAT])      inflight_d = inflight_q + IW'(1);
    else if (!tiv_q && tag_vld_q[LAT]) inflight_d = inflight_q - IW'(1);
  end

  // Scheduler FSM with registered grant, select, valid and busy outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      tiv_q   <= 1'b0;
      sel_q   <= '0;
      last_q  <= SW'(CH - 1);
      busy_q  <= 1'b0;
    end else begin
      gnt_q <= '0;
      tiv_q <= 1'b0;
      sel_q <= '0;
      if (issue) begin
        gnt_q  <= CH'(1) << pick_idx;
        tiv_q  <= 1'b1;
        sel_q  <= pick_idx;
        last_q <= pick_idx;
      end
      case (state_q)
        IDLE: begin
          if (go) begin
            state_q <= RUN;
            busy_q  <= 1'b1;
          end
        end
        RUN: begin
          if (!go) begin
            if (inflight_d != '0) begin
              state_q <= DRAIN;
            end else begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end
          end
        end
        DRAIN: begin
          if (go) begin
            state_q <= RUN;
          end else if (inflight_d == '0) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Tag pipeline: stage LAT lines up with the tree output for the same issue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_vld_q <= '0;
      for (int i = 1; i <= LAT; i++) tag_ch_q[i] <= '0;
    end else begin
      tag_vld_q[1] <= tiv_q;
      tag_ch_q[1]  <= sel_q;
      for (int i = 2; i <= LAT; i++) begin
        tag_vld_q[i] <= tag_vld_q[i-1];
        tag_ch_q[i]  <= tag_ch_q[i-1];
      end
    end
  end

  // In-flight counter and the sticky tag/valid mismatch flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight_q <= '0;
      err_q      <= 1'b0;
    end else begin
      inflight_q <= inflight_d;
      if (tree_out_valid != tag_vld_q[LAT]) err_q <= 1'b1;
    end
  end

  assign gnt           = gnt_q;
  assign tree_in_valid = tiv_q;
  assign tree_sel      = sel_q;
  assign busy          = busy_q;
  assign err           = err_q;
  assign res_valid     = tree_out_valid & tag_vld_q[LAT];
  assign res_ch        = res_valid ? tag_ch_q[LAT] : '0;

endmodule
